mem_access: RTL

- Memory stage directly downstream of the execute stage.
- Consumes the ALU result as a byte address and the forwarded register operand as store data.
- Performs word loads and stores on an internal data memory with a fixed multi-cycle latency, and stalls upstream while busy.
- Hands a registered result (load data or pass-through ALU result) to writeback with a one-cycle valid pulse.

---
 rtl/mem_access_pkg.sv | 18 +
 rtl/data_mem.sv | 31 +++
 rtl/mem_access.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared constants and types for the memory-access stage.
//   MEM_IDLE / MEM_BUSY : FSM state encodings
//   DATA_W              : data word width
//   WORD_OFFSET         : low address bits dropped to form a word index
package mem_access_pkg;

   localparam logic MEM_IDLE = 1'b0;
   localparam logic MEM_BUSY = 1'b1;

   localparam int unsigned DATA_W      = 32;
   localparam int unsigned WORD_OFFSET = 2;

   typedef enum logic {
      StIdle = MEM_IDLE,
      StBusy = MEM_BUSY
   } mem_state_e;

endpackage

// File: rtl/data_mem.sv
// data_mem: word-addressed data storage, synchronous write, combinational read.
// Ports:
//   clk   - clock, rising edge
//   we    - write enable, commits wdata at the clock edge
//   index - word index
//   wdata - write data
//   rdata - read data for index (combinational)
// Contents are never reset.
module data_mem
   import mem_access_pkg::*;
#(
   parameter int unsigned ADDR_BITS = 8
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] index,
   input  logic [DATA_W-1:0]    wdata,
   output logic [DATA_W-1:0]    rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_BITS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[index] <= wdata;
      end
   end

   assign rdata = mem[index];

endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage between execute and writeback.
// Word loads/stores with a fixed LATENCY (1..15) from accept to the valid_out
// pulse; non-memory instructions pass the ALU result through in one cycle.
// Ports:
//   clk, reset         - clock and synchronous active-high reset
//   valid_in           - execute stage presents an instruction
//   memRead, memWrite  - load / store request (both set counts as a store)
//   address            - ALU result, byte address for memory ops
//   writeData          - store data
//   stall              - upstream must hold (combinational)
//   valid_out          - one-cycle pulse, readData/aluResult_out valid
//   readData           - load data, 0 for non-loads
//   aluResult_out      - registered copy of the accepted address
module mem_access
   import mem_access_pkg::*;
#(
   parameter int unsigned LATENCY   = 3,
   parameter int unsigned ADDR_BITS = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic [DATA_W-1:0] address,
   input  logic [DATA_W-1:0] writeData,
   output logic              stall,
   output logic              valid_out,
   output logic [DATA_W-1:0] readData,
   output logic [DATA_W-1:0] aluResult_out
);

   // Busy cycles remaining after the accept cycle, minus one.
   localparam logic [3:0] CntInit = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   mem_state_e        state;
   logic [3:0]        counter;
   logic [DATA_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              is_store_q;

   logic                 mem_op;
   logic                 accept_now;
   logic                 finish_busy;
   logic                 we;
   logic [DATA_W-1:0]    idx_addr;
   logic [ADDR_BITS-1:0] index;
   logic [DATA_W-1:0]    mem_wdata;
   logic [DATA_W-1:0]    mem_rdata;

   assign mem_op      = valid_in & (memRead | memWrite);
   // LATENCY==1: the access happens at the end of the accept cycle itself.
   assign accept_now  = (LATENCY == 1) && (state == StIdle) && mem_op;
   assign finish_busy = (state == StBusy) && (counter == 4'd0);

   // In IDLE the live inputs address memory; in BUSY the latched op does.
   assign idx_addr  = (state == StIdle) ? address : addr_q;
   assign index     = idx_addr[ADDR_BITS+WORD_OFFSET-1:WORD_OFFSET];
   assign mem_wdata = (state == StIdle) ? writeData : wdata_q;

   // Reset wins: an aborted store must never reach the array.
   assign we = ~reset & ((accept_now & memWrite) | (finish_busy & is_store_q));

   assign stall = (LATENCY > 1) &&
                  (((state == StIdle) && mem_op) || ((state == StBusy) && (counter != 4'd0)));

   data_mem #(
      .ADDR_BITS(ADDR_BITS)
   ) u_data_mem (
      .clk  (clk),
      .we   (we),
      .index(index),
      .wdata(mem_wdata),
      .rdata(mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= StIdle;
         counter       <= 4'd0;
         valid_out     <= 1'b0;
         readData      <= '0;
         aluResult_out <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         is_store_q    <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         unique case (state)
            StIdle: begin
               if (valid_in) begin
                  if (!(memRead || memWrite)) begin
                     aluResult_out <= address;
                     readData      <= '0;
                     valid_out     <= 1'b1;
                  end else if (LATENCY == 1) begin
                     aluResult_out <= address;
                     readData      <= memWrite ? '0 : mem_rdata;
                     valid_out     <= 1'b1;
                  end else begin
                     addr_q     <= address;
                     wdata_q    <= writeData;
                     is_store_q <= memWrite;
                     counter    <= CntInit;
                     state      <= StBusy;
                  end
               end
            end
            StBusy: begin
               if (counter == 4'd0) begin
                  aluResult_out <= addr_q;
                  readData      <= is_store_q ? '0 : mem_rdata;
                  valid_out     <= 1'b1;
                  state         <= StIdle;
               end else begin
                  counter <= counter - 4'd1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
